evm_monitor: RTL and testbench

- Downstream of the RX subsystem, clk_dsp domain. Consumes demodulated 16-QAM symbols (demod_I/Q/valid) and hard-slices each one to the nearest ideal point.
- Accumulates the squared error vector over a fixed window and publishes a mean-square error (MSE) per window, plus a 2-bit quality grade.
- The grade drives the LED indicators and the renderer overlay, giving an on-board measure of channel noise that replaces the button-level guess.

---
 rtl/evm_monitor.sv | 169 ++++++++++++++++
 tb/tb_evm_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/evm_monitor.sv
// 16-QAM EVM monitor: slices each symbol, averages the squared error over a window, grades the result.
// Optional EVM_PEAK_EN adds peak_err and forces grade 0 when one symbol in the window has a large error.
module evm_monitor #(
    parameter int DATA_W      = 16,
    parameter int LEVEL_A     = 2048,
    parameter int WINDOW_LOG2 = 10,
    parameter int TH_GOOD     = 4096,
    parameter int TH_FAIR     = 16384,
    parameter int TH_POOR     = 65536
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] sym_I,
    input  logic signed [DATA_W-1:0] sym_Q,
    input  logic                     sym_valid,
    output logic [1:0]               dec_I,
    output logic [1:0]               dec_Q,
    output logic                     dec_valid,
    output logic [2*DATA_W+1:0]      mse,
    output logic                     mse_valid,
    output logic [1:0]               grade,
    output logic [WINDOW_LOG2-1:0]   win_count
`ifdef EVM_PEAK_EN
    ,
    output logic [2*DATA_W+1:0]      peak_err
`endif
);

    localparam int ERR_W = DATA_W + 1;
    localparam int X_W   = DATA_W + 2;
    localparam int E2_W  = 2*DATA_W + 2;
    localparam int ACC_W = E2_W + WINDOW_LOG2;

    localparam logic signed [X_W-1:0] ZERO = '0;
    localparam logic signed [X_W-1:0] A1   = X_W'(LEVEL_A);
    localparam logic signed [X_W-1:0] A2   = X_W'(2*LEVEL_A);
    localparam logic signed [X_W-1:0] A3   = X_W'(3*LEVEL_A);
    localparam logic [E2_W-1:0] T_GOOD = E2_W'(TH_GOOD);
    localparam logic [E2_W-1:0] T_FAIR = E2_W'(TH_FAIR);
    localparam logic [E2_W-1:0] T_POOR = E2_W'(TH_POOR);

    typedef struct packed {
        logic [1:0]              dec;
        logic signed [ERR_W-1:0] err;
    } slice_t;

    // Positive-side inclusive thresholds; outliers are measured against the outer point.
    function automatic slice_t slice(input logic signed [DATA_W-1:0] x);
        logic signed [X_W-1:0] xe;
        logic signed [X_W-1:0] ideal;
        slice_t s;
        xe = X_W'(x);
        if (xe < -A2) begin
            s.dec = 2'b00; ideal = -A3;
        end else if (xe < ZERO) begin
            s.dec = 2'b01; ideal = -A1;
        end else if (xe < A2) begin
            s.dec = 2'b11; ideal = A1;
        end else begin
            s.dec = 2'b10; ideal = A3;
        end
        s.err = ERR_W'(xe - ideal);
        return s;
    endfunction

    function automatic logic [1:0] grade_of(input logic [E2_W-1:0] m);
        if (m < T_GOOD)      return 2'd3;
        else if (m < T_FAIR) return 2'd2;
        else if (m < T_POOR) return 2'd1;
        else                 return 2'd0;
    endfunction

    slice_t si, sq;
    assign si = slice(sym_I);
    assign sq = slice(sym_Q);

    logic signed [ERR_W-1:0] err_i, err_q;
    logic                    v1, v2;
    logic [E2_W-1:0]         e2;
    logic [ACC_W-1:0]        acc;

    logic signed [E2_W-1:0]  ei, eq;
    logic [E2_W-1:0]         sq_sum;
    logic [ACC_W-1:0]        acc_sum;
    logic [E2_W-1:0]         mse_next;

    always_comb begin
        ei       = E2_W'(err_i);
        eq       = E2_W'(err_q);
        sq_sum   = $unsigned(ei * ei) + $unsigned(eq * eq);
        acc_sum  = acc + ACC_W'(e2);
        mse_next = acc_sum[ACC_W-1:WINDOW_LOG2];
    end

`ifdef EVM_PEAK_EN
    logic [E2_W-1:0] peak_cur, peak_next;
    assign peak_next = (e2 > peak_cur) ? e2 : peak_cur;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_I     <= '0;
            dec_Q     <= '0;
            dec_valid <= 1'b0;
            err_i     <= '0;
            err_q     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            e2        <= '0;
            acc       <= '0;
            win_count <= '0;
            mse       <= '0;
            mse_valid <= 1'b0;
            grade     <= '0;
`ifdef EVM_PEAK_EN
            peak_cur  <= '0;
            peak_err  <= '0;
`endif
        end else begin
            mse_valid <= 1'b0;
            if (en) begin
                dec_valid <= sym_valid;
                if (sym_valid) begin
                    dec_I <= si.dec;
                    dec_Q <= sq.dec;
                    err_i <= si.err;
                    err_q <= sq.err;
                end
                if (v1) e2 <= sq_sum;
            end
            // clear drops everything in flight behind the slicer, including a coincident symbol.
            if (clear) begin
                v1        <= 1'b0;
                v2        <= 1'b0;
                acc       <= '0;
                win_count <= '0;
`ifdef EVM_PEAK_EN
                peak_cur  <= '0;
`endif
            end else if (en) begin
                v1 <= sym_valid;
                v2 <= v1;
                if (v2) begin
                    win_count <= win_count + 1'b1;
                    if (&win_count) begin
                        acc       <= '0;
                        mse       <= mse_next;
                        mse_valid <= 1'b1;
`ifdef EVM_PEAK_EN
                        peak_err  <= peak_next;
                        peak_cur  <= '0;
                        grade     <= (peak_next >= T_POOR) ? 2'd0 : grade_of(mse_next);
`else
                        grade     <= grade_of(mse_next);
`endif
                    end else begin
                        acc <= acc_sum;
`ifdef EVM_PEAK_EN
                        peak_cur <= peak_next;
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_evm_monitor.sv
// Directed bench for evm_monitor: slicing, window MSE/grade, clear, enable gating, reset.
module tb_evm_monitor;
    localparam logic signed [15:0] PA  = 16'sd2048;
    localparam logic signed [15:0] M3A = -16'sd6144;
`ifdef EVM_PEAK_EN
    localparam logic [1:0] PEAK_GRADE = 2'd0;
`else
    localparam logic [1:0] PEAK_GRADE = 2'd3;
`endif

    logic clk = 1'b0;
    logic rst, en, clear, sym_valid;
    logic signed [15:0] sym_I, sym_Q;
    logic [1:0]  dec_I, dec_Q, grade;
    logic        dec_valid, mse_valid;
    logic [33:0] mse;
    logic [9:0]  win_count;
`ifdef EVM_PEAK_EN
    logic [33:0] peak_err;
`endif

    int checks = 0, failures = 0, pulses = 0, p0 = 0;

    evm_monitor dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .sym_I(sym_I), .sym_Q(sym_Q), .sym_valid(sym_valid),
        .dec_I(dec_I), .dec_Q(dec_Q), .dec_valid(dec_valid),
        .mse(mse), .mse_valid(mse_valid), .grade(grade), .win_count(win_count)
`ifdef EVM_PEAK_EN
        , .peak_err(peak_err)
`endif
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (mse_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input logic signed [15:0] i, input logic signed [15:0] q);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sym_I = i; sym_Q = q; sym_valid = 1'b1;
        end
    endtask

    // mse_valid must appear exactly 3 cycles after the last symbol.
    task automatic expect_mse(input string tag, input logic [63:0] m, input logic [1:0] g);
        @(negedge clk); sym_valid = 1'b0;
        chk({tag, "_early1"}, mse_valid, 0);
        @(negedge clk);
        chk({tag, "_early2"}, mse_valid, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, mse_valid, 1);
        chk({tag, "_mse"}, mse, m);
        chk({tag, "_grade"}, grade, g);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; sym_valid = 1'b0; sym_I = '0; sym_Q = '0;
        repeat (3) @(negedge clk);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_I", dec_I, 0);
        chk("rst_mse", mse, 0);
        chk("rst_mse_valid", mse_valid, 0);
        chk("rst_grade", grade, 0);
        chk("rst_win_count", win_count, 0);
`ifdef EVM_PEAK_EN
        chk("rst_peak", peak_err, 0);
`endif
        rst = 1'b0;

        // Ideal (+A,-3A) window
        send(1024, PA, M3A);
        expect_mse("ideal", 0, 2'd3);
        chk("ideal_dec_I", dec_I, 2'b11);
        chk("ideal_dec_Q", dec_Q, 2'b00);
        chk("ideal_wc", win_count, 0);

        // +100 offset both axes: e2 = 20000
        send(1024, 16'sd2148, -16'sd6044);
        expect_mse("offset", 20000, 2'd1);

        // Slicer boundaries
        send(1, 16'sd0, M3A);
        @(negedge clk); sym_valid = 1'b0;
        chk("b_zero", dec_I, 2'b11);
        chk("b_zero_v", dec_valid, 1);
        send(1, 16'sd4096, M3A);
        @(negedge clk); sym_valid = 1'b0;
        chk("b_p2a", dec_I, 2'b10);
        send(1, -16'sd4096, M3A);
        @(negedge clk); sym_valid = 1'b0;
        chk("b_m2a", dec_I, 2'b01);
        send(1, 16'sd32767, M3A);
        @(negedge clk); sym_valid = 1'b0;
        chk("b_max", dec_I, 2'b10);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_clr_wc", win_count, 0);
        chk("b_clr_mse", mse, 20000);

        // Outlier 32767: err = 26623, e2 = 708784129, mse = 692172
        send(1023, PA, M3A);
        send(1, 16'sd32767, M3A);
        expect_mse("far", 692172, 2'd0);
`ifdef EVM_PEAK_EN
        chk("far_peak", peak_err, 708784129);
`endif

        // clear after 500 symbols, coincident symbol sliced but not counted
        send(500, PA, M3A);
        @(negedge clk);
        sym_I = M3A; sym_Q = M3A; sym_valid = 1'b1; clear = 1'b1;
        @(negedge clk); clear = 1'b0; sym_valid = 1'b0;
        chk("clr_dec_I", dec_I, 2'b00);
        chk("clr_dec_valid", dec_valid, 1);
        repeat (2) @(negedge clk);
        chk("clr_wc", win_count, 0);
        chk("clr_mse_kept", mse, 692172);
        chk("clr_grade_kept", grade, 0);
        p0 = pulses;
        send(1024, PA, M3A);
        expect_mse("post_clr", 0, 2'd3);
        @(negedge clk);
        chk("clr_one_pulse", pulses - p0, 1);

        // en low for 50 cycles with sym_valid high
        send(300, PA, M3A);
        @(negedge clk); sym_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("en_wc_before", win_count, 300);
        @(negedge clk);
        en = 1'b0; sym_valid = 1'b1; sym_I = 16'sd32767; sym_Q = 16'sd32767;
        repeat (49) @(negedge clk);
        chk("en_wc_frozen", win_count, 300);
        chk("en_dec_valid_held", dec_valid, 0);
        @(negedge clk); en = 1'b1; sym_valid = 1'b0;
        send(724, PA, M3A);
        expect_mse("en_gap", 0, 2'd3);

        // One symbol with error (300,400): e2 = 250000, mse = 244
        send(1023, PA, M3A);
        send(1, 16'sd2348, -16'sd5744);
        expect_mse("peak", 244, PEAK_GRADE);
`ifdef EVM_PEAK_EN
        chk("peak_err", peak_err, 250000);
`endif

        // Reset mid-window
        send(100, PA, M3A);
        @(negedge clk); rst = 1'b1; sym_valid = 1'b0;
        #1;
        chk("mrst_wc", win_count, 0);
        chk("mrst_mse", mse, 0);
        chk("mrst_grade", grade, 0);
        chk("mrst_dec_valid", dec_valid, 0);
        @(negedge clk); rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
